// File: rtl/id_branch_hazard_pkg.sv
// Shared ID-stage constants: opcodes, functs, PC-select encodings and decode record.
// Pure definitions; no logic, no latency, no flow control.
package id_branch_hazard_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;

  localparam logic [2:0] SEL_NONE   = 3'b000;
  localparam logic [2:0] SEL_BRANCH = 3'b100;
  localparam logic [2:0] SEL_JUMP   = 3'b010;
  localparam logic [2:0] SEL_JR     = 3'b001;

  localparam logic [4:0] REG_RA     = 5'd31;

  typedef struct packed {
    logic [4:0] dest;
    logic       use_rs;
    logic       use_rt;
    logic       is_beq;
    logic       is_bne;
    logic       is_jump;   // j or jal
    logic       is_jr;     // jr or jalr
    logic       mem_read;
  } dec_t;

  // Word offset of a branch, truncated to the 31 bits that take part in the add.
  function automatic logic [30:0] branch_offset(input logic [15:0] imm);
    return {{13{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/id_decode.sv
// Instruction field decode for the ID stage: destination, source use, control-flow flags.
// Purely combinational, zero latency; no flow control.
// Backpressure: none, output follows the instruction fields directly.
module id_decode
  import id_branch_hazard_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [5:0] funct,
  output dec_t       dec
);

  logic is_r;
  logic two_src;

  assign is_r    = (op == OP_RTYPE);
  assign two_src = is_r || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);

  always_comb begin
    dec          = '0;
    dec.is_beq   = (op == OP_BEQ);
    dec.is_bne   = (op == OP_BNE);
    dec.is_jump  = (op == OP_J) || (op == OP_JAL);
    dec.is_jr    = is_r && ((funct == FUNCT_JR) || (funct == FUNCT_JALR));
    dec.mem_read = (op == OP_LW);

    if (is_r) begin
      dec.dest = (funct == FUNCT_JR) ? 5'd0 : rd;
    end else if (op == OP_JAL) begin
      dec.dest = REG_RA;
    end else if ((op[5:3] == 3'b001) || (op == OP_LW)) begin
      dec.dest = rt;
    end

    // $0 is hard-wired, so reading it can never create a dependency.
    dec.use_rs = !dec.is_jump && (rs != 5'd0);
    dec.use_rt = two_src && (rt != 5'd0);
  end

endmodule

// File: rtl/id_branch_hazard.sv
// ID stage with branch resolution, load-use / branch-operand hazard stall and ID_EX register.
// Latency: 1 cycle IF_ID -> id_ex_*; stall holds IF via PC_IF_ID_Write=0 and inserts a bubble.
module id_branch_hazard
  import id_branch_hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] IF_ID,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic        PC_IF_ID_Write,
  output logic [2:0]  select_PC_next,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target,
  output logic [31:0] jr_target,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_pc_plus4,
  output logic [31:0] id_ex_instr,
  output logic [31:0] id_ex_rs_data,
  output logic [31:0] id_ex_rt_data,
  output logic [4:0]  id_ex_dest,
  output logic        id_ex_mem_read,
  output logic        id_ex_reg_write
);

  logic [31:0] pc4;
  logic [31:0] instr;
  dec_t        dec;
  logic [4:0]  mem_load_dest;
  logic        is_branch;
  logic        rs_hazard;
  logic        rt_hazard;
  logic        stall;

  assign pc4     = IF_ID[63:32];
  assign instr   = IF_ID[31:0];
  assign rs_addr = instr[25:21];
  assign rt_addr = instr[20:16];

  id_decode u_decode (
    .op    (instr[31:26]),
    .rs    (instr[25:21]),
    .rt    (instr[20:16]),
    .rd    (instr[15:11]),
    .funct (instr[5:0]),
    .dec   (dec)
  );

  assign branch_target = {pc4[31], pc4[30:0] + branch_offset(instr[15:0])};
  assign jump_target   = {pc4[31:28], instr[25:0], 2'b00};
  assign jr_target     = rs_data;

  // Branches compare in ID, so they also wait on an ALU result still in EX
  // and on a load result one stage further down.
  assign is_branch = dec.is_beq || dec.is_bne || dec.is_jr;

  assign rs_hazard = dec.use_rs &&
                     (((rs_addr == id_ex_dest) && (id_ex_mem_read || (is_branch && id_ex_reg_write))) ||
                      (is_branch && (rs_addr == mem_load_dest)));
  assign rt_hazard = dec.use_rt &&
                     (((rt_addr == id_ex_dest) && (id_ex_mem_read || (is_branch && id_ex_reg_write))) ||
                      (is_branch && (rt_addr == mem_load_dest)));

  assign stall          = rs_hazard || rt_hazard;
  assign PC_IF_ID_Write = !stall;

  always_comb begin
    select_PC_next = SEL_NONE;
    if (!stall) begin
      if ((dec.is_beq && (rs_data == rt_data)) || (dec.is_bne && (rs_data != rt_data))) begin
        select_PC_next = SEL_BRANCH;
      end else if (dec.is_jump) begin
        select_PC_next = SEL_JUMP;
      end else if (dec.is_jr) begin
        select_PC_next = SEL_JR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_load_dest   <= '0;
      id_ex_valid     <= 1'b0;
      id_ex_pc_plus4  <= '0;
      id_ex_instr     <= '0;
      id_ex_rs_data   <= '0;
      id_ex_rt_data   <= '0;
      id_ex_dest      <= '0;
      id_ex_mem_read  <= 1'b0;
      id_ex_reg_write <= 1'b0;
    end else begin
      mem_load_dest <= id_ex_mem_read ? id_ex_dest : 5'd0;
      if (stall) begin
        id_ex_valid     <= 1'b0;
        id_ex_pc_plus4  <= '0;
        id_ex_instr     <= '0;
        id_ex_rs_data   <= '0;
        id_ex_rt_data   <= '0;
        id_ex_dest      <= '0;
        id_ex_mem_read  <= 1'b0;
        id_ex_reg_write <= 1'b0;
      end else begin
        id_ex_valid     <= (IF_ID != 64'd0);
        id_ex_pc_plus4  <= pc4;
        id_ex_instr     <= instr;
        id_ex_rs_data   <= rs_data;
        id_ex_rt_data   <= rt_data;
        id_ex_dest      <= dec.dest;
        id_ex_mem_read  <= dec.mem_read;
        id_ex_reg_write <= (dec.dest != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_id_branch_hazard.sv
// Scoreboard bench for id_branch_hazard: a stimulus process acts as the IF stage and queues
// expectations from an instruction-level hazard model; a negedge monitor pops and compares.
module tb_id_branch_hazard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] IF_ID = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [4:0]  rs_addr, rt_addr;
  logic        PC_IF_ID_Write;
  logic [2:0]  select_PC_next;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc_plus4, id_ex_instr, id_ex_rs_data, id_ex_rt_data;
  logic [4:0]  id_ex_dest;
  logic        id_ex_mem_read, id_ex_reg_write;

  always #5 clk = ~clk;

  id_branch_hazard dut (
    .clk(clk), .rst_n(rst_n), .IF_ID(IF_ID), .rs_data(rs_data), .rt_data(rt_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .PC_IF_ID_Write(PC_IF_ID_Write),
    .select_PC_next(select_PC_next), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .id_ex_valid(id_ex_valid),
    .id_ex_pc_plus4(id_ex_pc_plus4), .id_ex_instr(id_ex_instr),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
    .id_ex_dest(id_ex_dest), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_reg_write(id_ex_reg_write)
  );

  typedef enum int {K_ADD, K_ADDI, K_ORI, K_LW, K_SW, K_BEQ, K_BNE,
                    K_J, K_JAL, K_JR, K_JALR, K_BUB} kind_t;

  typedef struct {
    int          tag;
    logic        wr;
    logic [2:0]  sel;
    logic [31:0] bt, jt, jrt;
    logic [4:0]  rsa, rta;
  } comb_exp_t;

  typedef struct {
    int          tag;
    logic        v;
    logic [31:0] pc4, ins, a, b;
    logic [4:0]  dest;
    logic        mr, rw;
  } ex_exp_t;

  comb_exp_t cq[$];
  ex_exp_t   xq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dut_stalls = 0;
  bit mon_en = 1'b0;

  // Producers still ahead of ID: one cycle ahead (EX) and two cycles ahead (MEM).
  logic [4:0] ex1_dest = '0, ex2_dest = '0;
  bit         ex1_load = 1'b0, ex2_load = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc(input kind_t k, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [15:0] imm,
                                      input logic [25:0] tgt);
    case (k)
      K_ADD:  return {6'h00, rs, rt, rd, 5'h00, 6'h20};
      K_JR:   return {6'h00, rs, rt, rd, 5'h00, 6'h08};
      K_JALR: return {6'h00, rs, rt, rd, 5'h00, 6'h09};
      K_ADDI: return {6'b001000, rs, rt, imm};
      K_ORI:  return {6'b001101, rs, rt, imm};
      K_LW:   return {6'b100011, rs, rt, imm};
      K_SW:   return {6'b101011, rs, rt, imm};
      K_BEQ:  return {6'b000100, rs, rt, imm};
      K_BNE:  return {6'b000101, rs, rt, imm};
      K_J:    return {6'b000010, tgt};
      K_JAL:  return {6'b000011, tgt};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] dest_of(input kind_t k, input logic [31:0] ins);
    case (k)
      K_ADD, K_JALR:       return ins[15:11];
      K_JAL:               return 5'd31;
      K_ADDI, K_ORI, K_LW: return ins[20:16];
      default:             return 5'd0;
    endcase
  endfunction

  task automatic model_step(input kind_t k, input logic [63:0] ifid, input logic [31:0] a,
                            input logic [31:0] b, output bit st);
    logic [31:0] ins, pc4, off, sum;
    logic [4:0]  s, d;
    bit          br, used;
    comb_exp_t   ce;
    ex_exp_t     xe;
    ins = ifid[31:0];
    pc4 = ifid[63:32];
    br  = k inside {K_BEQ, K_BNE, K_JR, K_JALR};
    st  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s    = (i == 0) ? ins[25:21] : ins[20:16];
      used = (i == 0) ? !(k inside {K_J, K_JAL, K_BUB})
                      : (k inside {K_ADD, K_JR, K_JALR, K_BEQ, K_BNE, K_SW});
      if (used && s != 5'd0 &&
          ((ex1_load && ex1_dest == s) || (br && ex1_dest == s) || (br && ex2_load && ex2_dest == s)))
        st = 1'b1;
    end
    off = {{14{ins[15]}}, ins[15:0], 2'b00};
    sum = pc4 + off;
    ce.tag = cyc;
    ce.wr  = !st;
    ce.sel = 3'b000;
    if (!st) begin
      if ((k == K_BEQ && a == b) || (k == K_BNE && a != b)) ce.sel = 3'b100;
      else if (k == K_J || k == K_JAL)                      ce.sel = 3'b010;
      else if (k == K_JR || k == K_JALR)                    ce.sel = 3'b001;
    end
    ce.bt  = {pc4[31], sum[30:0]};
    ce.jt  = {pc4[31:28], ins[25:0], 2'b00};
    ce.jrt = a;
    ce.rsa = ins[25:21];
    ce.rta = ins[20:16];
    cq.push_back(ce);
    d = st ? 5'd0 : dest_of(k, ins);
    xe.tag  = cyc + 1;
    xe.v    = !st && (ifid != 64'd0);
    xe.pc4  = st ? 32'd0 : pc4;
    xe.ins  = st ? 32'd0 : ins;
    xe.a    = st ? 32'd0 : a;
    xe.b    = st ? 32'd0 : b;
    xe.dest = d;
    xe.mr   = !st && (k == K_LW);
    xe.rw   = (d != 5'd0);
    xq.push_back(xe);
    ex2_dest = ex1_dest;
    ex2_load = ex1_load;
    ex1_dest = d;
    ex1_load = !st && (k == K_LW);
  endtask

  // Acts as IF: presents the instruction and holds it for as long as ID should stall.
  task automatic issue(input kind_t k, input logic [31:0] ins, input logic [31:0] pc4,
                       input logic [31:0] a, input logic [31:0] b);
    bit st;
    int tries = 0;
    do begin
      @(posedge clk);
      #1;
      IF_ID   = (k == K_BUB) ? 64'd0 : {pc4, ins};
      rs_data = a;
      rt_data = b;
      model_step(k, IF_ID, a, b, st);
      tries++;
    end while (st && tries < 4);
  endtask

  always @(negedge clk) begin : monitor
    comb_exp_t e;
    ex_exp_t   x;
    if (mon_en) begin
      if (!PC_IF_ID_Write) dut_stalls++;
      while (cq.size() != 0 && cq[0].tag <= cyc) begin
        e = cq.pop_front();
        if (e.tag < cyc) begin
          chk("comb_expect_missed", cyc, e.tag);
        end else begin
          chk("pc_if_id_write", PC_IF_ID_Write, e.wr);
          chk("select_pc_next", select_PC_next, e.sel);
          chk("branch_target", branch_target, e.bt);
          chk("jump_target", jump_target, e.jt);
          chk("jr_target", jr_target, e.jrt);
          chk("rs_addr", rs_addr, e.rsa);
          chk("rt_addr", rt_addr, e.rta);
        end
      end
      while (xq.size() != 0 && xq[0].tag <= cyc) begin
        x = xq.pop_front();
        if (x.tag < cyc) begin
          chk("ex_expect_missed", cyc, x.tag);
        end else begin
          chk("id_ex_valid", id_ex_valid, x.v);
          chk("id_ex_pc_plus4", id_ex_pc_plus4, x.pc4);
          chk("id_ex_instr", id_ex_instr, x.ins);
          chk("id_ex_rs_data", id_ex_rs_data, x.a);
          chk("id_ex_rt_data", id_ex_rt_data, x.b);
          chk("id_ex_dest", id_ex_dest, x.dest);
          chk("id_ex_mem_read", id_ex_mem_read, x.mr);
          chk("id_ex_reg_write", id_ex_reg_write, x.rw);
        end
      end
    end
  end

  task automatic random_run(input int n);
    kind_t       k;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      k = kind_t'($urandom_range(0, 11));
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? a : $urandom;
      issue(k, enc(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 16'($urandom), 26'($urandom)),
            $urandom, a, b);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_id_ex_valid", id_ex_valid, 1'b0);
    chk("rst_id_ex_dest", id_ex_dest, 5'd0);
    chk("rst_id_ex_mem_read", id_ex_mem_read, 1'b0);
    chk("rst_id_ex_instr", id_ex_instr, 32'd0);
    chk("rst_pc_if_id_write", PC_IF_ID_Write, 1'b1);
    chk("rst_select", select_PC_next, 3'b000);
    #19 rst_n = 1'b1;
    mon_en = 1'b1;

    // Taken beq with a positive offset.
    issue(K_BEQ, enc(K_BEQ, 5'd1, 5'd2, 5'd0, 16'd3, 26'd0), 32'h0000_0104, 32'd5, 32'd5);
    #1;
    chk("beq_sel", select_PC_next, 3'b100);
    chk("beq_target", branch_target, 32'h0000_0110);
    chk("beq_write", PC_IF_ID_Write, 1'b1);

    // Load-use on an ALU op: one bubble.
    issue(K_LW, enc(K_LW, 5'd0, 5'd3, 5'd0, 16'h0010, 26'd0), 32'h0000_0200, 32'd0, 32'd0);
    @(negedge clk); #1 dut_stalls = 0;
    issue(K_ADD, enc(K_ADD, 5'd3, 5'd5, 5'd4, 16'd0, 26'd0), 32'h0000_0204, 32'd7, 32'd9);
    @(negedge clk); #1;
    chk("lw_alu_stalls", dut_stalls, 1);

    // Load feeding a branch: two bubbles.
    issue(K_LW, enc(K_LW, 5'd0, 5'd3, 5'd0, 16'h0020, 26'd0), 32'h0000_0300, 32'd0, 32'd0);
    @(negedge clk); #1 dut_stalls = 0;
    issue(K_BEQ, enc(K_BEQ, 5'd3, 5'd0, 5'd0, 16'd2, 26'd0), 32'h0000_0304, 32'd0, 32'd0);
    #1;
    chk("lw_beq_sel_after", select_PC_next, 3'b100);
    @(negedge clk); #1;
    chk("lw_beq_stalls", dut_stalls, 2);

    // ALU result feeding a bne: one bubble.
    issue(K_ADD, enc(K_ADD, 5'd1, 5'd2, 5'd6, 16'd0, 26'd0), 32'h0000_0400, 32'd1, 32'd2);
    @(negedge clk); #1 dut_stalls = 0;
    issue(K_BNE, enc(K_BNE, 5'd6, 5'd0, 5'd0, 16'd4, 26'd0), 32'h0000_0404, 32'd1, 32'd0);
    @(negedge clk); #1;
    chk("alu_bne_stalls", dut_stalls, 1);

    // Jumps.
    issue(K_J, enc(K_J, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000040), 32'h8000_0010, 32'd0, 32'd0);
    #1;
    chk("j_sel", select_PC_next, 3'b010);
    chk("j_target", jump_target, 32'h8000_0100);
    issue(K_JR, enc(K_JR, 5'd7, 5'd0, 5'd0, 16'd0, 26'd0), 32'h0000_0500, 32'h0040_0020, 32'd0);
    #1;
    chk("jr_sel", select_PC_next, 3'b001);
    chk("jr_target_val", jr_target, 32'h0040_0020);

    // Branch target wraps inside bits 30:0, bit 31 kept.
    issue(K_BEQ, enc(K_BEQ, 5'd1, 5'd2, 5'd0, 16'd1, 26'd0), 32'h7FFF_FFFC, 32'd9, 32'd9);
    #1;
    chk("wrap_target", branch_target, 32'h0000_0000);

    random_run(400);

    // Reset asserted while a load-use branch is stalled.
    issue(K_LW, enc(K_LW, 5'd0, 5'd3, 5'd0, 16'h0040, 26'd0), 32'h0000_0600, 32'd0, 32'd0);
    @(posedge clk); #1;
    IF_ID = {32'h0000_0604, enc(K_BEQ, 5'd3, 5'd0, 5'd0, 16'd2, 26'd0)};
    #1;
    chk("midstall_write", PC_IF_ID_Write, 1'b0);
    @(negedge clk); #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_id_ex_valid", id_ex_valid, 1'b0);
    chk("midrst_id_ex_dest", id_ex_dest, 5'd0);
    chk("midrst_id_ex_mem_read", id_ex_mem_read, 1'b0);
    chk("midrst_id_ex_reg_write", id_ex_reg_write, 1'b0);
    chk("midrst_id_ex_pc_plus4", id_ex_pc_plus4, 32'd0);
    cq.delete();
    xq.delete();
    ex1_dest = '0; ex2_dest = '0; ex1_load = 1'b0; ex2_load = 1'b0;
    IF_ID = '0; rs_data = '0; rt_data = '0;
    #1;
    chk("midrst_write", PC_IF_ID_Write, 1'b1);
    chk("midrst_select", select_PC_next, 3'b000);
    @(posedge clk); #3 rst_n = 1'b1;
    mon_en = 1'b1;
    dut_stalls = 0;
    issue(K_BEQ, enc(K_BEQ, 5'd3, 5'd0, 5'd0, 16'd2, 26'd0), 32'h0000_0604, 32'd1, 32'd1);
    @(negedge clk); #1;
    chk("no_residual_stall", dut_stalls, 0);

    random_run(100);
    issue(K_BUB, 32'd0, 32'd0, 32'd0, 32'd0);
    issue(K_BUB, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("queues_drained", cq.size() + xq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_branch_hazard.md
ID_BRANCH_HAZARD -- requirements
Module: id_branch_hazard

Interface
REQ-001 SHALL have ports: clk in 1 clock; rst_n in 1 async active-low reset; IF_ID in 64 {PC+4[63:32], instr[31:0]}, all-zero = bubble.
REQ-002 SHALL have ports: rs_data in 32 and rt_data in 32 (forwarded operands, MEM/WB forwarding external); rs_addr out 5 = instr[25:21]; rt_addr out 5 = instr[20:16].
REQ-003 SHALL have ports: PC_IF_ID_Write out 1 (0 = stall IF); select_PC_next out 3 {Z,J,Jr}, one-hot or 000.
REQ-004 SHALL have ports: branch_target out 32; jump_target out 32; jr_target out 32.
REQ-005 SHALL have registered ports: id_ex_valid 1, id_ex_pc_plus4 32, id_ex_instr 32, id_ex_rs_data 32, id_ex_rt_data 32, id_ex_dest 5, id_ex_mem_read 1, id_ex_reg_write 1.

Function
REQ-006 SHALL decode: beq 000100, bne 000101, j 000010, jal 000011, lw 100011, sw 101011; jr = op 0 funct 001000; jalr = op 0 funct 001001.
REQ-007 SHALL compute dest: op 0 -> rd, except jr -> 0; jal -> 31; op 001xxx or lw -> rt; else 0; reg_write = (dest != 0).
REQ-008 SHALL define source use: R-type, beq, bne, sw use rs and rt; other I-type uses rs only; j/jal use none; register 0 never counts as a use.
REQ-009 SHALL compute branch_target = {pc4[31], (pc4[30:0] + (sext(imm16) << 2))[30:0]}, combinational; bit 31 preserved.
REQ-010 SHALL compute jump_target = {pc4[31:28], instr[25:0], 2'b00} and jr_target = rs_data, both combinational.
REQ-011 SHALL track mem_load_dest internally: each cycle <= (id_ex_mem_read ? id_ex_dest : 0).
REQ-012 SHALL assert stall when a used source s matches: (a) id_ex_dest with id_ex_mem_read; or (b) id_ex_dest with id_ex_reg_write, when ID holds beq/bne/jr/jalr; or (c) mem_load_dest, when ID holds beq/bne/jr/jalr.
REQ-013 On stall: PC_IF_ID_Write = 0; select_PC_next = 000, so no IF flush during a stall; ID_EX <= bubble (all fields 0) on next edge.
REQ-014 Without stall: PC_IF_ID_Write = 1; ID_EX <= decoded fields with valid = (IF_ID != 0), next edge; latency 1 cycle.
REQ-015 Without stall: select = 100 if beq with rs_data == rt_data, or bne with rs_data != rt_data; 010 for j/jal; 001 for jr/jalr; else 000.
REQ-016 Taken branch squashes the following instruction via IF flush; j/jal/jr/jalr keep one delay slot, unflushed.
REQ-017 lw followed by a dependent branch SHALL stall exactly 2 cycles; a dependent ALU op followed by a branch stalls 1; lw followed by a dependent ALU op stalls 1.
REQ-018 A bubble in IF_ID SHALL never stall, never redirect, and SHALL produce id_ex_valid = 0.
REQ-019 Outputs SHALL be combinational from IF_ID, rs_data, rt_data, and internal registers only; no combinational input-to-input loops.

Reset
REQ-020 rst_n low SHALL asynchronously clear all id_ex_* registers and mem_load_dest to 0.
REQ-021 Because IF_ID is zero in reset, outputs during reset SHALL read PC_IF_ID_Write = 1 and select_PC_next = 000.
REQ-022 Reset deasserted mid-stall SHALL resume with no residual stall.

Structure
REQ-023 Opcode/funct constants, the select_PC_next encodings, and the register-31 constant SHALL live in the shared pipeline package.
REQ-024 Decode (dest, uses, type flags) SHALL be one sub-module, id_decode, instantiated for ID; stall and select logic and ID_EX registers stay in the top.

Verification
REQ-025 IF_ID = {0x00000104, beq $1,$2,+3}, rs = rt = 5 -> select 100, branch_target 0x00000110, PC_IF_ID_Write = 1.
REQ-026 ID_EX = lw $3; ID = add $4,$3,$5 -> 1 cycle: PC_IF_ID_Write = 0, bubble; next cycle add passes with valid = 1.
REQ-027 lw $3, then beq $3,$0 -> exactly 2 stall cycles, select 000 while stalled, then 100 or 000 per operand compare.
REQ-028 IF_ID = {0x80000010, j 0x0000040} -> select 010, jump_target 0x80000100; jr with rs_data = 0x00400020 -> select 001, jr_target 0x00400020.
REQ-029 PC+4 = 0x7FFFFFFC, beq offset +1, taken -> branch_target 0x00000000 (bit 31 kept 0, wrap in bits 30:0).
REQ-030 rst_n pulsed low mid-stall -> id_ex_* = 0 immediately; after release, IF_ID = 0 gives PC_IF_ID_Write = 1 and select 000.
